beta_decode_stage: RTL and testbench

//  Decode stage of the Beta pipeline; sits directly upstream of the register file.
//  - Registers one fetched instruction per cycle.
//  - Decodes it into regfile controls (ra, rb, rc, ra2sel, wasel, werf) plus operand and trap info for execute.
//  - Handles valid/ready flow control, load-use interlock, branch flush and illegal-op/interrupt traps.

---
 rtl/beta_isa_pkg.sv | 57 +++++
 rtl/beta_inst_decode.sv | 64 ++++++
 rtl/beta_decode_stage.sv | 150 +++++++++++++++
 tb/tb_beta_decode_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/beta_isa_pkg.sv
// ----------------------------------------------------------------------------
// beta_isa_pkg
//   Shared Beta ISA definitions for the decode stage. It provides:
//     - opcode values and ALU opcode ranges
//     - trap encodings
//     - special register numbers
//     - the decode-stage output register bundle
//   No ports; imported by beta_inst_decode and beta_decode_stage.
// ----------------------------------------------------------------------------
package beta_isa_pkg;

   // Memory / control-flow opcodes
   localparam logic [5:0] OP_LD      = 6'h18;
   localparam logic [5:0] OP_ST      = 6'h19;
   localparam logic [5:0] OP_JMP     = 6'h1B;
   localparam logic [5:0] OP_BEQ     = 6'h1C;
   localparam logic [5:0] OP_BNE     = 6'h1D;
   localparam logic [5:0] OP_LDR     = 6'h1F;

   // Register-form and literal-form ALU ranges (inclusive)
   localparam logic [5:0] OP_ALU_LO  = 6'h20;
   localparam logic [5:0] OP_ALU_HI  = 6'h2E;
   localparam logic [5:0] OP_ALUC_LO = 6'h30;
   localparam logic [5:0] OP_ALUC_HI = 6'h3E;

   // Special registers
   localparam logic [4:0] R_XP       = 5'd30;
   localparam logic [4:0] R_ZERO     = 5'd31;

   typedef enum logic [1:0] {
      TRAP_NONE  = 2'b00,
      TRAP_ILLOP = 2'b01,
      TRAP_IRQ   = 2'b10
   } trap_e;

   // Everything the decode pipeline register carries except the valid bit
   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rc;
      logic        ra2sel;
      logic        wasel;
      logic        werf;
      logic        bsel;
      logic [31:0] lit;
      logic [31:0] pc;
      trap_e       trap;
   } dec_out_t;

   function automatic logic in_range(input logic [5:0] op,
                                     input logic [5:0] lo,
                                     input logic [5:0] hi);
      return (op >= lo) && (op <= hi);
   endfunction

endpackage

// File: rtl/beta_inst_decode.sv
// ----------------------------------------------------------------------------
// beta_inst_decode
//   Purely combinational field extraction and opcode classification.
//   Ports:
//     inst_i      in   32  Beta instruction word
//     opcode_o    out  6   inst[31:26]
//     ra_o        out  5   inst[20:16]
//     rb_o        out  5   inst[15:11]
//     rc_o        out  5   inst[25:21]
//     lit_o       out  32  sign-extended inst[15:0]
//     ra2sel_o    out  1   second read port uses rc (ST only)
//     werf_raw_o  out  1   opcode writes the register file (before R31 masking)
//     bsel_o      out  1   literal operand
//     illop_o     out  1   opcode is not a defined instruction
//     uses_rb_o   out  1   rb is a real source (register-form ALU)
//     uses_rc_o   out  1   rc is a real source (ST)
// ----------------------------------------------------------------------------
module beta_inst_decode
   import beta_isa_pkg::*;
(
   input  logic [31:0] inst_i,
   output logic [5:0]  opcode_o,
   output logic [4:0]  ra_o,
   output logic [4:0]  rb_o,
   output logic [4:0]  rc_o,
   output logic [31:0] lit_o,
   output logic        ra2sel_o,
   output logic        werf_raw_o,
   output logic        bsel_o,
   output logic        illop_o,
   output logic        uses_rb_o,
   output logic        uses_rc_o
);

   logic [5:0] op;
   logic       alu_reg;
   logic       alu_lit;
   logic       is_st;

   assign op       = inst_i[31:26];
   assign opcode_o = op;
   assign rc_o     = inst_i[25:21];
   assign ra_o     = inst_i[20:16];
   assign rb_o     = inst_i[15:11];
   assign lit_o    = {{16{inst_i[15]}}, inst_i[15:0]};

   always_comb begin
      alu_reg    = in_range(op, OP_ALU_LO, OP_ALU_HI);
      alu_lit    = in_range(op, OP_ALUC_LO, OP_ALUC_HI);
      is_st      = (op == OP_ST);

      werf_raw_o = alu_reg || alu_lit ||
                   (op == OP_LD)  || (op == OP_LDR) ||
                   (op == OP_JMP) || (op == OP_BEQ) || (op == OP_BNE);
      ra2sel_o   = is_st;
      // Whole 0x30-0x3F block selects the literal, even the undefined 0x3F.
      bsel_o     = (op[5:4] == 2'b11) || (op == OP_LD) ||
                   is_st || (op == OP_LDR);
      illop_o    = !(werf_raw_o || is_st);
      uses_rb_o  = alu_reg;
      uses_rc_o  = is_st;
   end

endmodule

// File: rtl/beta_decode_stage.sv
// ----------------------------------------------------------------------------
// beta_decode_stage
//   Decode stage of the Beta pipeline, directly upstream of the register file.
//   Registers one fetched instruction per cycle. It decodes the instruction
//   into regfile controls plus operand and trap info for execute.
//   It also handles:
//     - valid/ready flow control
//     - the load-use interlock
//     - branch flush
//     - illegal-op and interrupt traps
//   Ports:
//     clock, reset         clock; async active-high reset
//     ifu_valid/ifu_ready  fetch handshake; ifu_inst/ifu_pc the instruction
//     irq                  level interrupt, ignored in supervisor mode (pc[31])
//     flush                taken branch in execute, kills decode contents
//     ex_ld_valid/ex_ld_rc load in execute and its destination (interlock)
//     dec_valid/dec_ready  downstream handshake
//     ra, rb, rc, ra2sel, wasel, werf       regfile controls
//     dec_opcode, dec_bsel, dec_lit, dec_pc, dec_trap  execute info
// ----------------------------------------------------------------------------
module beta_decode_stage
   import beta_isa_pkg::*;
#(
   parameter logic [31:0] XADDR_PC = 32'h8000_0008
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        ifu_valid,
   input  logic [31:0] ifu_inst,
   input  logic [31:0] ifu_pc,
   output logic        ifu_ready,
   input  logic        irq,
   input  logic        flush,
   input  logic        ex_ld_valid,
   input  logic [4:0]  ex_ld_rc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [4:0]  ra,
   output logic [4:0]  rb,
   output logic [4:0]  rc,
   output logic        ra2sel,
   output logic        wasel,
   output logic        werf,
   output logic [5:0]  dec_opcode,
   output logic        dec_bsel,
   output logic [31:0] dec_lit,
   output logic [31:0] dec_pc,
   output logic [1:0]  dec_trap
);

   logic [5:0]  op_w;
   logic [4:0]  ra_w, rb_w, rc_w;
   logic [31:0] lit_w;
   logic        ra2sel_w, werf_raw_w, bsel_w, illop_w, uses_rb_w, uses_rc_w;

   dec_out_t    dec_d, dec_q;
   logic        dec_valid_q;

   logic        adv;
   logic        hazard;
   logic        irq_take;
   logic [4:0]  src2;

   beta_inst_decode u_dec (
      .inst_i     (ifu_inst),
      .opcode_o   (op_w),
      .ra_o       (ra_w),
      .rb_o       (rb_w),
      .rc_o       (rc_w),
      .lit_o      (lit_w),
      .ra2sel_o   (ra2sel_w),
      .werf_raw_o (werf_raw_w),
      .bsel_o     (bsel_w),
      .illop_o    (illop_w),
      .uses_rb_o  (uses_rb_w),
      .uses_rc_o  (uses_rc_w)
   );

   // Downstream slot is free, or is being emptied this cycle.
   assign adv = !dec_valid_q || dec_ready;

   // Load-use interlock: R31 is never a real destination, so a load into it
   // cannot create a dependency.
   assign src2   = uses_rc_w ? rc_w : rb_w;
   assign hazard = ex_ld_valid && (ex_ld_rc != R_ZERO) &&
                   ((ra_w == ex_ld_rc) ||
                    ((uses_rb_w || uses_rc_w) && (src2 == ex_ld_rc)));

   // During a flush, fetch may hand over freely: whatever it gives is dropped.
   assign ifu_ready = adv && (!hazard || flush);

   assign irq_take = irq && !ifu_pc[31];

   always_comb begin
      dec_d        = '0;
      dec_d.opcode = op_w;
      dec_d.ra     = ra_w;
      dec_d.rb     = rb_w;
      dec_d.rc     = rc_w;
      dec_d.lit    = lit_w;
      dec_d.bsel   = bsel_w;
      dec_d.ra2sel = ra2sel_w;
      dec_d.wasel  = 1'b0;
      dec_d.werf   = werf_raw_w && (rc_w != R_ZERO);
      dec_d.pc     = ifu_pc;
      dec_d.trap   = TRAP_NONE;
      // Traps write the return address into XP, so werf ignores rc==31.
      if (irq_take) begin
         dec_d.trap   = TRAP_IRQ;
         dec_d.wasel  = 1'b1;
         dec_d.werf   = 1'b1;
         dec_d.ra2sel = 1'b0;
         dec_d.pc     = XADDR_PC;
      end else if (illop_w) begin
         dec_d.trap   = TRAP_ILLOP;
         dec_d.wasel  = 1'b1;
         dec_d.werf   = 1'b1;
         dec_d.pc     = XADDR_PC;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dec_q       <= '0;
         dec_valid_q <= 1'b0;
      end else if (flush) begin
         dec_valid_q <= 1'b0;
      end else if (adv && hazard) begin
         // Bubble: fetch sees ifu_ready=0 and holds its instruction.
         dec_valid_q <= 1'b0;
      end else if (adv) begin
         dec_q       <= dec_d;
         dec_valid_q <= ifu_valid;
      end
   end

   assign dec_valid  = dec_valid_q;
   assign ra         = dec_q.ra;
   assign rb         = dec_q.rb;
   assign rc         = dec_q.rc;
   assign ra2sel     = dec_q.ra2sel;
   assign wasel      = dec_q.wasel;
   assign werf       = dec_q.werf;
   assign dec_opcode = dec_q.opcode;
   assign dec_bsel   = dec_q.bsel;
   assign dec_lit    = dec_q.lit;
   assign dec_pc     = dec_q.pc;
   assign dec_trap   = dec_q.trap;

endmodule

// File: tb/tb_beta_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_beta_decode_stage
//   Directed test of beta_decode_stage. Inputs change 1 ns after the rising
//   edge and outputs are sampled there as well.
// ----------------------------------------------------------------------------
module tb_beta_decode_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        ifu_valid;
   logic [31:0] ifu_inst;
   logic [31:0] ifu_pc;
   logic        ifu_ready;
   logic        irq;
   logic        flush;
   logic        ex_ld_valid;
   logic [4:0]  ex_ld_rc;
   logic        dec_valid;
   logic        dec_ready;
   logic [4:0]  ra, rb, rc;
   logic        ra2sel, wasel, werf;
   logic [5:0]  dec_opcode;
   logic        dec_bsel;
   logic [31:0] dec_lit;
   logic [31:0] dec_pc;
   logic [1:0]  dec_trap;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [31:0] XADDR = 32'h8000_0008;

   beta_decode_stage dut (
      .clock       (clock),
      .reset       (reset),
      .ifu_valid   (ifu_valid),
      .ifu_inst    (ifu_inst),
      .ifu_pc      (ifu_pc),
      .ifu_ready   (ifu_ready),
      .irq         (irq),
      .flush       (flush),
      .ex_ld_valid (ex_ld_valid),
      .ex_ld_rc    (ex_ld_rc),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .ra          (ra),
      .rb          (rb),
      .rc          (rc),
      .ra2sel      (ra2sel),
      .wasel       (wasel),
      .werf        (werf),
      .dec_opcode  (dec_opcode),
      .dec_bsel    (dec_bsel),
      .dec_lit     (dec_lit),
      .dec_pc      (dec_pc),
      .dec_trap    (dec_trap)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; ifu_valid = 1'b0; ifu_inst = '0; ifu_pc = '0;
      irq = 1'b0; flush = 1'b0; ex_ld_valid = 1'b0; ex_ld_rc = '0; dec_ready = 1'b1;
      #3;
      n_chk++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", dec_valid); end
      n_chk++; if ({ra, rb, rc} !== 15'd0) begin n_fail++; $display("FAIL rst_regs got %h want 0", {ra, rb, rc}); end
      n_chk++; if ({werf, wasel, ra2sel, dec_bsel, dec_trap} !== 6'd0) begin n_fail++; $display("FAIL rst_ctl got %b want 0", {werf, wasel, ra2sel, dec_bsel, dec_trap}); end
      n_chk++; if (dec_pc !== 32'd0 || dec_lit !== 32'd0) begin n_fail++; $display("FAIL rst_pc_lit got %h/%h want 0", dec_pc, dec_lit); end
      n_chk++; if (ifu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ifu_ready got %b want 1", ifu_ready); end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_alu();
      // ADD R3,R1,R2
      ifu_valid = 1'b1; ifu_inst = 32'h8061_1000; ifu_pc = 32'h0000_0040; dec_ready = 1'b1;
      #1;
      n_chk++; if (ifu_ready !== 1'b1) begin n_fail++; $display("FAIL add_ifu_ready got %b want 1", ifu_ready); end
      tick();
      ifu_valid = 1'b0;
      n_chk++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", dec_valid); end
      n_chk++; if (ra !== 5'd1 || rb !== 5'd2 || rc !== 5'd3) begin n_fail++; $display("FAIL add_regs got %0d/%0d/%0d want 1/2/3", ra, rb, rc); end
      n_chk++; if ({werf, wasel, ra2sel, dec_bsel} !== 4'b1000) begin n_fail++; $display("FAIL add_ctl got %b want 1000", {werf, wasel, ra2sel, dec_bsel}); end
      n_chk++; if (dec_opcode !== 6'h20 || dec_pc !== 32'h40 || dec_trap !== 2'b00) begin n_fail++; $display("FAIL add_info got %h/%h/%b want 20/40/00", dec_opcode, dec_pc, dec_trap); end
      // ADDC R1,R2,-1 : negative literal sign-extends
      ifu_valid = 1'b1; ifu_inst = 32'hC022_FFFF; ifu_pc = 32'h44;
      tick();
      n_chk++; if (dec_lit !== 32'hFFFF_FFFF || dec_bsel !== 1'b1 || werf !== 1'b1) begin n_fail++; $display("FAIL addc_lit got %h/%b/%b want ffffffff/1/1", dec_lit, dec_bsel, werf); end
      // ADD R31,R1,R2 : R31 never written
      ifu_inst = 32'h83E1_1000; ifu_pc = 32'h48;
      tick();
      n_chk++; if (werf !== 1'b0 || wasel !== 1'b0 || rc !== 5'd31) begin n_fail++; $display("FAIL r31_werf got werf=%b wasel=%b rc=%0d want 0/0/31", werf, wasel, rc); end
      ifu_valid = 1'b0;
      tick();
   endtask

   task automatic test_store();
      // ST R5,8(R2)
      ifu_valid = 1'b1; ifu_inst = 32'h64A2_0008; ifu_pc = 32'h50;
      tick();
      ifu_valid = 1'b0;
      n_chk++; if (dec_valid !== 1'b1 || ra2sel !== 1'b1 || werf !== 1'b0 || dec_bsel !== 1'b1) begin n_fail++; $display("FAIL st_ctl got v=%b ra2sel=%b werf=%b bsel=%b want 1/1/0/1", dec_valid, ra2sel, werf, dec_bsel); end
      n_chk++; if (dec_lit !== 32'd8 || rc !== 5'd5 || ra !== 5'd2) begin n_fail++; $display("FAIL st_fields got lit=%h rc=%0d ra=%0d want 8/5/2", dec_lit, rc, ra); end
      tick();
   endtask

   task automatic test_hazard();
      // ADD R6,R4,R4 behind LD into R4
      ex_ld_valid = 1'b1; ex_ld_rc = 5'd4;
      ifu_valid = 1'b1; ifu_inst = 32'h80C4_2000; ifu_pc = 32'h60;
      #1;
      n_chk++; if (ifu_ready !== 1'b0) begin n_fail++; $display("FAIL haz_ready got %b want 0", ifu_ready); end
      tick();
      n_chk++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL haz_bubble got %b want 0", dec_valid); end
      ex_ld_valid = 1'b0;
      #1;
      n_chk++; if (ifu_ready !== 1'b1) begin n_fail++; $display("FAIL haz_release got %b want 1", ifu_ready); end
      tick();
      ifu_valid = 1'b0;
      n_chk++; if (dec_valid !== 1'b1 || ra !== 5'd4 || rb !== 5'd4 || rc !== 5'd6) begin n_fail++; $display("FAIL haz_issue got v=%b %0d/%0d/%0d want 1 4/4/6", dec_valid, ra, rb, rc); end
      // ST R5,8(R2) behind LD into R5: rc is a source for ST
      ex_ld_valid = 1'b1; ex_ld_rc = 5'd5; ifu_valid = 1'b1; ifu_inst = 32'h64A2_0008;
      #1;
      n_chk++; if (ifu_ready !== 1'b0) begin n_fail++; $display("FAIL haz_st_rc got %b want 0", ifu_ready); end
      // ADDC R1,R3,0x1000: rb field = 2 but is a literal, no interlock
      ex_ld_rc = 5'd2; ifu_inst = 32'hC023_1000;
      #1;
      n_chk++; if (ifu_ready !== 1'b1) begin n_fail++; $display("FAIL haz_lit_rb got %b want 1", ifu_ready); end
      // Load into R31 never interlocks
      ex_ld_rc = 5'd31; ifu_inst = 32'h83FF_F800;
      #1;
      n_chk++; if (ifu_ready !== 1'b1) begin n_fail++; $display("FAIL haz_r31 got %b want 1", ifu_ready); end
      ex_ld_valid = 1'b0; ifu_valid = 1'b0;
      tick();
   endtask

   task automatic test_trap();
      ifu_valid = 1'b1; ifu_inst = 32'h0; ifu_pc = 32'h100; irq = 1'b0;
      tick();
      n_chk++; if (dec_trap !== 2'b01 || wasel !== 1'b1 || werf !== 1'b1 || dec_pc !== XADDR) begin n_fail++; $display("FAIL illop got trap=%b wasel=%b werf=%b pc=%h want 01/1/1/80000008", dec_trap, wasel, werf, dec_pc); end
      irq = 1'b1;
      tick();
      n_chk++; if (dec_trap !== 2'b10 || wasel !== 1'b1 || werf !== 1'b1 || dec_pc !== XADDR) begin n_fail++; $display("FAIL irq_user got trap=%b wasel=%b werf=%b pc=%h want 10/1/1/80000008", dec_trap, wasel, werf, dec_pc); end
      ifu_pc = 32'h8000_0100;
      tick();
      n_chk++; if (dec_trap !== 2'b01 || dec_pc !== XADDR) begin n_fail++; $display("FAIL irq_super got trap=%b pc=%h want 01/80000008", dec_trap, dec_pc); end
      // Legal ADD in user mode with irq pending becomes an interrupt
      ifu_inst = 32'h8061_1000; ifu_pc = 32'h200;
      tick();
      n_chk++; if (dec_trap !== 2'b10 || wasel !== 1'b1 || dec_pc !== XADDR) begin n_fail++; $display("FAIL irq_add got trap=%b wasel=%b pc=%h want 10/1/80000008", dec_trap, wasel, dec_pc); end
      // Same ADD in supervisor mode decodes normally
      ifu_pc = 32'h8000_0200;
      tick();
      n_chk++; if (dec_trap !== 2'b00 || wasel !== 1'b0 || dec_pc !== 32'h8000_0200) begin n_fail++; $display("FAIL add_super got trap=%b wasel=%b pc=%h want 00/0/80000200", dec_trap, wasel, dec_pc); end
      irq = 1'b0; ifu_valid = 1'b0;
      tick();
   endtask

   task automatic test_stall_flush();
      ifu_valid = 1'b1; ifu_inst = 32'h8061_1000; ifu_pc = 32'h300; dec_ready = 1'b1;
      tick();
      // Stall cycle 1
      dec_ready = 1'b0; ifu_inst = 32'h64A2_0008; ifu_pc = 32'h304;
      #1;
      n_chk++; if (ifu_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready1 got %b want 0", ifu_ready); end
      tick();
      // Stall cycle 2, with flush
      n_chk++; if (dec_valid !== 1'b1 || rc !== 5'd3 || dec_pc !== 32'h300 || ra2sel !== 1'b0) begin n_fail++; $display("FAIL stall_hold got v=%b rc=%0d pc=%h ra2sel=%b want 1/3/300/0", dec_valid, rc, dec_pc, ra2sel); end
      n_chk++; if (ifu_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready2 got %b want 0", ifu_ready); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_chk++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill got %b want 0", dec_valid); end
      // Stall cycle 3: slot empty, so fetch is accepted again
      #1;
      n_chk++; if (ifu_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", ifu_ready); end
      // Instruction handed over during a flush is dropped
      flush = 1'b1;
      tick();
      flush = 1'b0; ifu_valid = 1'b0; dec_ready = 1'b1;
      n_chk++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got %b want 0", dec_valid); end
      tick();
   endtask

   task automatic test_reset_mid();
      ifu_valid = 1'b1; ifu_inst = 32'h8061_1000; ifu_pc = 32'h400; dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0; ifu_inst = 32'h64A2_0008;
      #2;
      reset = 1'b1;
      #1;
      n_chk++; if (dec_valid !== 1'b0 || ra !== 5'd0 || werf !== 1'b0 || dec_pc !== 32'd0) begin n_fail++; $display("FAIL rst_async got v=%b ra=%0d werf=%b pc=%h want 0/0/0/0", dec_valid, ra, werf, dec_pc); end
      tick();
      reset = 1'b0; dec_ready = 1'b1; ifu_valid = 1'b0;
      tick();
      n_chk++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_noreplay got %b want 0", dec_valid); end
      ifu_valid = 1'b1; ifu_inst = 32'h80C4_2000; ifu_pc = 32'h500;
      tick();
      ifu_valid = 1'b0;
      n_chk++; if (dec_valid !== 1'b1 || rc !== 5'd6 || dec_pc !== 32'h500) begin n_fail++; $display("FAIL rst_first got v=%b rc=%0d pc=%h want 1/6/500", dec_valid, rc, dec_pc); end
      tick();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store();
      test_hazard();
      test_trap();
      test_stall_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
